// File: rtl/iq_wakeup.sv
// iq_wakeup: four-entry (parameterisable) collapsing issue-queue slice.
// Entries are kept age-ordered with index 0 the oldest and the valid
// entries packed from index 0. A CDB broadcast sets per-source ready bits.
// The oldest fully-ready entry is offered to the execution unit through a
// valid/ready handshake. Issue outputs are taken from registered state only,
// so there is no combinational path from the CDB to the issue port.

// 4-bit tag equality comparator; every tag compare in the queue uses one.
module iq_eq4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       eq_o
);
    assign eq_o = (a_i == b_i);
endmodule

// Structural invariants of the queue: valid bits form a contiguous run
// from index 0, and the occupancy counter equals the number of valid entries.
module iq_wakeup_chk #(
    parameter int ENTRIES = 4
) (
    input logic                             clk_i,
    input logic                             rst_ni,
    input logic [ENTRIES-1:0]               valid_i,
    input logic [$clog2(ENTRIES+1)-1:0]     occ_i
);
    localparam int CNT_W = $clog2(ENTRIES+1);

    logic [CNT_W-1:0]   cnt_s;
    logic [ENTRIES-1:0] vplus_s;
    logic               contig_s;

    // Population count of the valid vector and a contiguity test (0..01..1).
    always_comb begin
        cnt_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cnt_s = cnt_s + CNT_W'(valid_i[i]);
        end
        vplus_s  = valid_i + {{(ENTRIES-1){1'b0}}, 1'b1};
        contig_s = ((valid_i & vplus_s) == {ENTRIES{1'b0}});
    end

    a_queue_shape: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cnt_s == occ_i) && contig_s);
endmodule

module iq_wakeup #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 32
) (
    input  logic                           clk,
    input  logic                           rst_aL,
    input  logic                           flush,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [3:0]                     enq_src1_tag,
    input  logic [3:0]                     enq_src2_tag,
    input  logic                           enq_src1_rdy,
    input  logic                           enq_src2_rdy,
    input  logic [3:0]                     enq_dst_tag,
    input  logic [DATA_W-1:0]              enq_payload,
    input  logic                           cdb_valid,
    input  logic [3:0]                     cdb_tag,
    output logic                           iss_valid,
    input  logic                           iss_ready,
    output logic [3:0]                     iss_dst_tag,
    output logic [DATA_W-1:0]              iss_payload,
    output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);
    localparam int CNT_W = $clog2(ENTRIES+1);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 4;

    typedef struct packed {
        logic              valid;
        logic              s1_rdy;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [TAG_W-1:0]  s2_tag;
        logic [TAG_W-1:0]  dst_tag;
        logic [DATA_W-1:0] payload;
    } entry_t;

    entry_t             ent_q  [ENTRIES];
    entry_t             ent_d  [ENTRIES];
    // One extra always-empty slot so the top entry can shift in "nothing".
    entry_t             wake_s [ENTRIES+1];
    entry_t             new_s;

    logic [ENTRIES-1:0] m1_s;
    logic [ENTRIES-1:0] m2_s;
    logic               em1_s;
    logic               em2_s;

    logic [CNT_W-1:0]   occ_q;
    logic [CNT_W-1:0]   occ_d;
    logic [CNT_W-1:0]   wr_idx_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_found_s;
    logic               iss_fire_s;
    logic               enq_fire_s;
    logic               enq_ready_s;
    logic [ENTRIES-1:0] valid_vec_s;

    // Tag comparators: two per stored entry plus two for the incoming entry.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
        iq_eq4 u_cmp_s1 (.a_i(ent_q[g].s1_tag), .b_i(cdb_tag), .eq_o(m1_s[g]));
        iq_eq4 u_cmp_s2 (.a_i(ent_q[g].s2_tag), .b_i(cdb_tag), .eq_o(m2_s[g]));
    end

    iq_eq4 u_cmp_enq_s1 (.a_i(enq_src1_tag), .b_i(cdb_tag), .eq_o(em1_s));
    iq_eq4 u_cmp_enq_s2 (.a_i(enq_src2_tag), .b_i(cdb_tag), .eq_o(em2_s));

    // Apply this cycle's CDB wakeup to every stored entry before any shifting.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            wake_s[i]        = ent_q[i];
            wake_s[i].s1_rdy = ent_q[i].s1_rdy | (cdb_valid & ent_q[i].valid & m1_s[i]);
            wake_s[i].s2_rdy = ent_q[i].s2_rdy | (cdb_valid & ent_q[i].valid & m2_s[i]);
        end
        wake_s[ENTRIES] = '0;
    end

    // Oldest-first select over registered state only.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!sel_found_s && ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign enq_ready_s = (occ_q != CNT_W'(ENTRIES));

    // Next-state: collapse on issue, write the dispatched entry, then flush.
    always_comb begin
        iss_fire_s = sel_found_s & iss_ready;
        enq_fire_s = enq_valid & enq_ready_s;
        // When an issue fires the queue collapses by one, so the tail moves down.
        wr_idx_s   = occ_q - CNT_W'(iss_fire_s);

        new_s         = '0;
        new_s.valid   = 1'b1;
        new_s.s1_rdy  = enq_src1_rdy | (cdb_valid & em1_s);
        new_s.s2_rdy  = enq_src2_rdy | (cdb_valid & em2_s);
        new_s.s1_tag  = enq_src1_tag;
        new_s.s2_tag  = enq_src2_tag;
        new_s.dst_tag = enq_dst_tag;
        new_s.payload = enq_payload;

        for (int i = 0; i < ENTRIES; i++) begin
            if (enq_fire_s && (CNT_W'(i) == wr_idx_s)) begin
                ent_d[i] = new_s;
            end else if (iss_fire_s && (IDX_W'(i) >= sel_idx_s)) begin
                ent_d[i] = wake_s[i+1];
            end else begin
                ent_d[i] = wake_s[i];
            end
            // Flush overrides everything: no entry survives, no bit stays ready.
            ent_d[i].valid  = ent_d[i].valid  & ~flush;
            ent_d[i].s1_rdy = ent_d[i].s1_rdy & ~flush;
            ent_d[i].s2_rdy = ent_d[i].s2_rdy & ~flush;
        end

        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CNT_W'(enq_fire_s) - CNT_W'(iss_fire_s);
        end
    end

    // Entry array and occupancy counter registers.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            occ_q <= occ_d;
        end
    end

    // Collect valid bits for the structural checker.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec_s[i] = ent_q[i].valid;
        end
    end

    assign enq_ready   = enq_ready_s;
    assign iss_valid   = sel_found_s;
    assign iss_dst_tag = ent_q[sel_idx_s].dst_tag;
    assign iss_payload = ent_q[sel_idx_s].payload;
    assign occupancy   = occ_q;

    iq_wakeup_chk #(.ENTRIES(ENTRIES)) u_chk (
        .clk_i   (clk),
        .rst_ni  (rst_aL),
        .valid_i (valid_vec_s),
        .occ_i   (occ_q)
    );
endmodule

// File: doc/iq_wakeup.md
# iq_wakeup

Four-entry issue queue slice with tag-match wakeup. It sits between rename/dispatch and the execution unit, and consumes the 4-bit ROB tag equality compare. Each entry holds a dispatched instruction's two source tags, per-source ready bits, destination tag and opaque payload. Entries are woken by common data bus (CDB) broadcasts, and the oldest entry with both sources ready issues with a valid/ready handshake.

## Interface
- ENTRIES, 4, queue depth (legal values 2..8)
- DATA_W, 32, opaque payload width carried with each entry
- Tag width is fixed at 4 bits: every tag compare is one instance of the team's 4-bit equality comparator.

- clk  in  1  single clock; all state updates on rising edge
- rst_aL  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all entries
- enq_valid  in  1  dispatch offers an instruction
- enq_ready  out  1  queue can accept (not full)
- enq_src1_tag, enq_src2_tag  in  4 each  source ROB tags
- enq_src1_rdy, enq_src2_rdy  in  1 each  source already available at dispatch
- enq_dst_tag  in  4  destination ROB tag
- enq_payload  in  DATA_W  opaque payload
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  4  broadcast ROB tag
- iss_valid  out  1  an entry is issuable
- iss_ready  in  1  execution unit accepts
- iss_dst_tag  out  4  destination tag of the selected entry
- iss_payload  out  DATA_W  payload of the selected entry
- occupancy  out  $clog2(ENTRIES+1)  number of valid entries

## Operation
- Collapsing age-ordered array: entry 0 is the oldest, and valid entries are always contiguous from index 0.
- Per entry state: valid, src1_rdy, src2_rdy, src1_tag, src2_tag, dst_tag, payload.
- Wakeup: for each valid entry and each source, if cdb_valid and the stored tag equals cdb_tag, the source rdy bit is set at the next edge. A rdy bit already set stays set.
- Enqueue bypass: if enq_valid && enq_ready and cdb_valid and cdb_tag equals an incoming source tag, that source is written as ready, irrespective of enq_srcN_rdy.
- Select: the lowest index with valid && src1_rdy && src2_rdy. iss_valid, iss_dst_tag and iss_payload come combinationally from registered state only; there is no CDB-to-issue combinational path.
- Issue fire = iss_valid && iss_ready. The selected entry is removed, and all younger entries shift down one index in the same edge, carrying any wakeup applied that cycle.
- Enqueue fire = enq_valid && enq_ready. The new entry is written at index occupancy, or occupancy-1 if an issue fires in the same cycle.
- enq_ready = (occupancy != ENTRIES). It does not depend on iss_ready, so a full queue refuses enqueue even when an issue fires that cycle.
- When iss_valid=0, iss_dst_tag and iss_payload are don't-care, but must not be X after reset; entry fields reset to 0.
- flush=1: all valid bits clear at the next edge. flush has priority over enqueue, issue and wakeup. enq_ready stays combinational from the pre-flush occupancy.

## Timing
- Reset (async assert, any time): all valid and rdy bits = 0, occupancy = 0, iss_valid = 0, enq_ready = 1, iss_dst_tag = 0, iss_payload = 0.
- Enqueue with both sources ready (or bypassed): iss_valid=1 in the next cycle (1-cycle dispatch-to-issue).
- Wakeup: a CDB broadcast in cycle N that completes an entry's operands makes it issuable in cycle N+1.
- Issue: the entry disappears at the edge ending the fire cycle. The next-oldest ready entry may issue in the following cycle (back-to-back issue at 1 per cycle).
- Simultaneous enqueue + issue + wakeup in one cycle: all three apply. The shifted and new entries both observe that cycle's cdb_tag.
- Holding iss_ready=0 keeps the same selected entry stable unless an older entry becomes ready, in which case selection moves to the older one.
- Mid-operation reset discards all contents; there is no recovery state.

## Test plan
- Reset, then enqueue {src1=3 rdy, src2=5 rdy, dst=9, payload=0xA5A5A5A5} with iss_ready=1 -> iss_valid=1 next cycle with dst=9 and payload 0xA5A5A5A5; occupancy returns to 0 after fire.
- Enqueue src1=2 not-ready, src2=7 not-ready; broadcast 2, then 7 in later cycles -> iss_valid rises exactly one cycle after the tag-7 broadcast.
- Fill all 4 entries with not-ready sources -> enq_ready=0 and occupancy=4; broadcast each tag -> entries issue in age order 0,1,2,3 with iss_ready=1.
- Enqueue src1=6 not-ready while cdb_tag=6 is valid the same cycle -> entry is stored ready; issue occurs the next cycle.
- Entries A (oldest, blocked) and B (ready), iss_ready=0 -> B is selected; wake A -> selection switches to A the next cycle; with iss_ready=1 the fires are A then B.
- With 3 entries valid, assert flush together with enq_valid and cdb_valid -> occupancy=0 and iss_valid=0 next cycle. Separately, assert rst_aL=0 mid-cycle -> outputs take reset values immediately.
